icpit_irq_cond: RTL and testbench

- Per-source interrupt request conditioner that sits directly upstream of the ICPIT interrupt controller and drives its IREQ[7:0] inputs.
- Takes raw, possibly asynchronous, interrupt lines and produces clean, PCLK-synchronous requests.
- Per channel: synchronise, apply polarity, glitch-filter, then either pass as a level or latch as an edge event with software clear.
- Edge events are tracked with overrun detection.

---
 rtl/icpit_irq_cond_pkg.sv | 13 +
 rtl/icpit_irq_chan.sv | 90 +++++++++
 rtl/icpit_irq_cond.sv | 48 ++++
 tb/tb_icpit_irq_cond.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icpit_irq_cond_pkg.sv
// Shared constants and channel-mode encoding for the ICPIT interrupt request conditioner.
package icpit_irq_cond_pkg;

    localparam int NUM_SRC_DEF     = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_W_DEF      = 4;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/icpit_irq_chan.sv
// One interrupt channel: synchroniser, glitch filter, then level pass-through or
// edge-latched pending bit with sticky overrun.
module icpit_irq_chan
    import icpit_irq_cond_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_src,
    input  irq_mode_e         i_mode,
    input  logic              i_pol,
    input  logic [FILT_W-1:0] i_filt_len,
    input  logic              i_clr,
    output logic              o_pend,
    output logic              o_ovf
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_W-1:0]      r_cnt;
    logic                   r_f;
    logic                   r_f_d;
    logic                   r_pend;
    logic                   r_ovf;

    logic                   w_s;
    logic [FILT_W-1:0]      w_len;
    logic [FILT_W:0]        w_cnt_inc;
    logic                   w_rise;

    assign w_s       = ~(r_sync[SYNC_STAGES-1] ^ i_pol);
    assign w_len     = (i_filt_len == '0) ? FILT_W'(1) : i_filt_len;
    // One extra bit so cnt+1 cannot wrap before the comparison
    assign w_cnt_inc = {1'b0, r_cnt} + (FILT_W+1)'(1);
    assign w_rise    = r_f & ~r_f_d;

    // Synchroniser
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
        end
    end

    // Filter: f follows s only after s has differed for the full filter length
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_f   <= 1'b0;
            r_f_d <= 1'b0;
        end else begin
            r_f_d <= r_f;
            if (w_s == r_f) begin
                r_cnt <= '0;
            end else if (w_cnt_inc >= {1'b0, w_len}) begin
                r_f   <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc[FILT_W-1:0];
            end
        end
    end

    // Edge pending/overrun; a rise coinciding with CLR survives as a fresh event
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (i_mode == IRQ_LEVEL) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_rise) begin
            r_pend <= 1'b1;
            if (i_clr) begin
                r_ovf <= 1'b0;
            end else if (r_pend) begin
                r_ovf <= 1'b1;
            end
        end else if (i_clr) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end
    end

    assign o_pend = (i_mode == IRQ_EDGE) ? r_pend : r_f;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/icpit_irq_cond.sv
// Interrupt request conditioner: NUM_SRC independent channels feeding ICPIT IREQ,
// with a shared filter length and per-channel masking of the request output.
module icpit_irq_cond
    import icpit_irq_cond_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic [NUM_SRC-1:0] SRC_IN,
    input  logic [NUM_SRC-1:0] EDGE_MODE,
    input  logic [NUM_SRC-1:0] POL,
    input  logic [FILT_W-1:0]  FILT_LEN,
    input  logic [NUM_SRC-1:0] CLR,
    input  logic [NUM_SRC-1:0] MASK,
    output logic [NUM_SRC-1:0] IREQ,
    output logic [NUM_SRC-1:0] PEND,
    output logic [NUM_SRC-1:0] OVF
);

    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_ovf;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_chan
        icpit_irq_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_chan (
            .i_clk      (PCLK),
            .i_rst_n    (PRESETN),
            .i_src      (SRC_IN[g]),
            .i_mode     (irq_mode_e'(EDGE_MODE[g])),
            .i_pol      (POL[g]),
            .i_filt_len (FILT_LEN),
            .i_clr      (CLR[g]),
            .o_pend     (w_pend[g]),
            .o_ovf      (w_ovf[g])
        );
    end

    // Masking gates only the request; pending state is untouched
    assign PEND = w_pend;
    assign OVF  = w_ovf;
    assign IREQ = w_pend & ~MASK;

endmodule

// File: tb/tb_icpit_irq_cond.sv
// Directed bench for icpit_irq_cond: level latency, glitch rejection, edge events,
// overrun, CLR/rise collision, masking, async reset and minimum filter length.
module tb_icpit_irq_cond;

    logic       PCLK;
    logic       PRESETN;
    logic [7:0] SRC_IN;
    logic [7:0] EDGE_MODE;
    logic [7:0] POL;
    logic [3:0] FILT_LEN;
    logic [7:0] CLR;
    logic [7:0] MASK;
    logic [7:0] IREQ;
    logic [7:0] PEND;
    logic [7:0] OVF;

    int errors = 0;
    int checks = 0;

    icpit_irq_cond #(
        .NUM_SRC     (8),
        .SYNC_STAGES (2),
        .FILT_W      (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESETN   (PRESETN),
        .SRC_IN    (SRC_IN),
        .EDGE_MODE (EDGE_MODE),
        .POL       (POL),
        .FILT_LEN  (FILT_LEN),
        .CLR       (CLR),
        .MASK      (MASK),
        .IREQ      (IREQ),
        .PEND      (PEND),
        .OVF       (OVF)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Advance n rising edges; returns 1 time unit after the last edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic test_reset;
        PRESETN   = 1'b0;
        SRC_IN    = 8'b0000_0100;   // ch2 is active-low, so high is idle
        EDGE_MODE = 8'b0001_1100;   // ch2,3,4 edge; others level
        POL       = 8'b1111_1011;
        FILT_LEN  = 4'd3;
        CLR       = 8'h00;
        MASK      = 8'h00;
        tick(3);
        checks++;
        if ({IREQ, PEND, OVF} !== 24'h0) begin
            errors++;
            $display("FAIL reset_held: IREQ=%h PEND=%h OVF=%h want all 0", IREQ, PEND, OVF);
        end
        #2 PRESETN = 1'b1;
        tick(1);
        checks++;
        if ({IREQ, PEND, OVF} !== 24'h0) begin
            errors++;
            $display("FAIL reset_release: IREQ=%h PEND=%h OVF=%h want all 0", IREQ, PEND, OVF);
        end
    endtask

    task automatic test_level;
        SRC_IN[0] = 1'b1;
        tick(4);
        checks++;
        if (PEND[0] !== 1'b0) begin
            errors++;
            $display("FAIL level_rise_early: PEND0=%b want 0", PEND[0]);
        end
        tick(1);
        checks++;
        if (PEND[0] !== 1'b1 || IREQ[0] !== 1'b1) begin
            errors++;
            $display("FAIL level_rise: PEND0=%b IREQ0=%b want 1 1", PEND[0], IREQ[0]);
        end
        SRC_IN[0] = 1'b0;
        tick(4);
        checks++;
        if (PEND[0] !== 1'b1) begin
            errors++;
            $display("FAIL level_fall_early: PEND0=%b want 1", PEND[0]);
        end
        tick(1);
        checks++;
        if (PEND[0] !== 1'b0 || IREQ[0] !== 1'b0) begin
            errors++;
            $display("FAIL level_fall: PEND0=%b IREQ0=%b want 0 0", PEND[0], IREQ[0]);
        end
    endtask

    task automatic test_glitch;
        int hi_cnt;
        int first_hi;
        SRC_IN[1] = 1'b1;
        tick(2);
        SRC_IN[1] = 1'b0;
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (PEND[1] === 1'b1) hi_cnt++;
        end
        checks++;
        if (hi_cnt != 0) begin
            errors++;
            $display("FAIL glitch_2cyc: high cycles=%0d want 0", hi_cnt);
        end
        SRC_IN[1] = 1'b1;
        hi_cnt    = 0;
        first_hi  = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (i == 3) SRC_IN[1] = 1'b0;
            if (PEND[1] === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        checks++;
        if (hi_cnt != 3) begin
            errors++;
            $display("FAIL pulse_3cyc_width: high cycles=%0d want 3", hi_cnt);
        end
        checks++;
        if (first_hi != 5) begin
            errors++;
            $display("FAIL pulse_3cyc_start: first high edge=%0d want 5", first_hi);
        end
    endtask

    task automatic test_edge_ovf;
        SRC_IN[2] = 1'b0;           // active-low: falling edge is the event
        tick(5);
        checks++;
        if (PEND[2] !== 1'b0) begin
            errors++;
            $display("FAIL edge_early: PEND2=%b want 0", PEND[2]);
        end
        tick(1);
        checks++;
        if (PEND[2] !== 1'b1 || OVF[2] !== 1'b0) begin
            errors++;
            $display("FAIL edge_event: PEND2=%b OVF2=%b want 1 0", PEND[2], OVF[2]);
        end
        CLR[2] = 1'b1;
        tick(1);
        CLR[2] = 1'b0;
        checks++;
        if (PEND[2] !== 1'b0) begin
            errors++;
            $display("FAIL edge_clr: PEND2=%b want 0", PEND[2]);
        end
        SRC_IN[2] = 1'b1;
        tick(8);
        SRC_IN[2] = 1'b0;
        tick(10);
        checks++;
        if (PEND[2] !== 1'b1 || OVF[2] !== 1'b0) begin
            errors++;
            $display("FAIL edge_event2: PEND2=%b OVF2=%b want 1 0", PEND[2], OVF[2]);
        end
        SRC_IN[2] = 1'b1;
        tick(8);
        SRC_IN[2] = 1'b0;
        tick(10);
        checks++;
        if (PEND[2] !== 1'b1 || OVF[2] !== 1'b1) begin
            errors++;
            $display("FAIL edge_overrun: PEND2=%b OVF2=%b want 1 1", PEND[2], OVF[2]);
        end
        CLR[2] = 1'b1;
        tick(1);
        CLR[2] = 1'b0;
        checks++;
        if (PEND[2] !== 1'b0 || OVF[2] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: PEND2=%b OVF2=%b want 0 0", PEND[2], OVF[2]);
        end
        SRC_IN[2] = 1'b1;
        tick(8);
    endtask

    task automatic test_clr_collision_mask;
        SRC_IN[3] = 1'b1;
        tick(6);
        checks++;
        if (PEND[3] !== 1'b1) begin
            errors++;
            $display("FAIL coll_first_event: PEND3=%b want 1", PEND[3]);
        end
        SRC_IN[3] = 1'b0;
        tick(8);
        SRC_IN[3] = 1'b1;
        tick(5);
        CLR[3] = 1'b1;              // lands on the edge where the rise is seen
        tick(1);
        CLR[3] = 1'b0;
        checks++;
        if (PEND[3] !== 1'b1 || OVF[3] !== 1'b0) begin
            errors++;
            $display("FAIL clr_collision: PEND3=%b OVF3=%b want 1 0", PEND[3], OVF[3]);
        end
        tick(3);
        checks++;
        if (PEND[3] !== 1'b1 || OVF[3] !== 1'b0) begin
            errors++;
            $display("FAIL clr_collision_hold: PEND3=%b OVF3=%b want 1 0", PEND[3], OVF[3]);
        end
        MASK[3] = 1'b1;
        #1;
        checks++;
        if (IREQ[3] !== 1'b0 || PEND[3] !== 1'b1) begin
            errors++;
            $display("FAIL mask: IREQ3=%b PEND3=%b want 0 1", IREQ[3], PEND[3]);
        end
        tick(2);
        MASK[3] = 1'b0;
        #1;
        checks++;
        if (IREQ[3] !== 1'b1) begin
            errors++;
            $display("FAIL unmask: IREQ3=%b want 1", IREQ[3]);
        end
        CLR[3]    = 1'b1;
        SRC_IN[3] = 1'b0;
        tick(1);
        CLR[3] = 1'b0;
        tick(8);
    endtask

    task automatic test_async_reset;
        int ev_cnt;
        int ovf_seen;
        logic prev;
        SRC_IN[0] = 1'b1;
        SRC_IN[4] = 1'b1;
        tick(8);
        SRC_IN[4] = 1'b0;
        tick(8);
        SRC_IN[4] = 1'b1;
        tick(8);
        checks++;
        if (PEND[0] !== 1'b1 || PEND[4] !== 1'b1 || OVF[4] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: PEND0=%b PEND4=%b OVF4=%b want 1 1 1", PEND[0], PEND[4], OVF[4]);
        end
        #1 PRESETN = 1'b0;
        #1;
        checks++;
        if ({IREQ, PEND, OVF} !== 24'h0) begin
            errors++;
            $display("FAIL async_reset: IREQ=%h PEND=%h OVF=%h want all 0", IREQ, PEND, OVF);
        end
        tick(2);
        #2 PRESETN = 1'b1;
        tick(5);
        checks++;
        if (PEND[4] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: PEND4=%b want 0", PEND[4]);
        end
        prev     = PEND[4];
        ev_cnt   = 0;
        ovf_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (PEND[4] === 1'b1 && prev === 1'b0) ev_cnt++;
            if (OVF[4] !== 1'b0) ovf_seen++;
            prev = PEND[4];
        end
        checks++;
        if (ev_cnt != 1 || PEND[4] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_event: events=%0d PEND4=%b want 1 1", ev_cnt, PEND[4]);
        end
        checks++;
        if (ovf_seen != 0) begin
            errors++;
            $display("FAIL post_reset_ovf: OVF4 high cycles=%0d want 0", ovf_seen);
        end
    endtask

    task automatic test_min_filter;
        for (int fl = 0; fl < 2; fl++) begin
            FILT_LEN  = 4'(fl);
            SRC_IN[5] = 1'b1;
            tick(2);
            checks++;
            if (PEND[5] !== 1'b0) begin
                errors++;
                $display("FAIL minfilt_rise_early len=%0d: PEND5=%b want 0", fl, PEND[5]);
            end
            tick(1);
            checks++;
            if (PEND[5] !== 1'b1) begin
                errors++;
                $display("FAIL minfilt_rise len=%0d: PEND5=%b want 1", fl, PEND[5]);
            end
            SRC_IN[5] = 1'b0;
            tick(2);
            checks++;
            if (PEND[5] !== 1'b1) begin
                errors++;
                $display("FAIL minfilt_fall_early len=%0d: PEND5=%b want 1", fl, PEND[5]);
            end
            tick(1);
            checks++;
            if (PEND[5] !== 1'b0) begin
                errors++;
                $display("FAIL minfilt_fall len=%0d: PEND5=%b want 0", fl, PEND[5]);
            end
        end
        FILT_LEN = 4'd3;
    endtask

    initial begin
        test_reset();
        test_level();
        test_glitch();
        test_edge_ovf();
        test_clr_collision_mask();
        test_async_reset();
        test_min_filter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
